// File: rtl/alu_ctrl_exec_if.sv
// Op/result handshake bundle between the register-read stage, the ALU and writeback.
interface alu_ctrl_exec_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [3:0]       funct;
  logic             mext;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [3:0]       operation;
  logic             illegal;

  modport master (
    output in_valid, alu_op, funct, mext, a, b, out_ready,
    input  in_ready, out_valid, result, zero, operation, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, mext, a, b, out_ready,
    output in_ready, out_valid, result, zero, operation, illegal
  );
endinterface

// File: rtl/alu_ctrl_exec.sv
// ALU control decode + execute with a registered valid/ready result and an
// iterative shift-add multiplier (one partial product per cycle).
module alu_ctrl_exec #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  alu_ctrl_exec_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_ILL = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, result_q;
  logic [SW-1:0]    cnt_q;
  logic             out_valid_q, zero_q, illegal_q;
  logic [3:0]       op_q;

  logic [3:0]       op_d;
  logic [WIDTH-1:0] res_d;
  logic [SW-1:0]    shamt;
  logic             accept, out_free;

  assign shamt    = bus.b[SW-1:0];
  assign out_free = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state_q == IDLE) && out_free;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.operation = op_q;
  assign bus.illegal   = illegal_q;

  // Decode ALUOp/funct into an op code; anything unmatched falls to OP_ILL.
  always_comb begin
    op_d = OP_ILL;
    case (bus.alu_op)
      2'b00: op_d = OP_ADD;
      2'b01: op_d = OP_SUB;
      2'b10: begin
        if (!bus.mext) begin
          case (bus.funct)
            4'b0000: op_d = OP_ADD;
            4'b1000: op_d = OP_SUB;
            4'b0111: op_d = OP_AND;
            4'b0110: op_d = OP_OR;
            4'b0100: op_d = OP_XOR;
            4'b0001: op_d = OP_SLL;
            4'b0101: op_d = OP_SRL;
            4'b1101: op_d = OP_SRA;
            4'b0010: op_d = OP_SLT;
            default: op_d = OP_ILL;
          endcase
        end else if (MUL_EN && bus.funct == 4'b0000) begin
          op_d = OP_MUL;
        end
      end
      default: op_d = OP_ILL;
    endcase
  end

  // Single-cycle datapath; MUL and illegal ops produce 0 here.
  always_comb begin
    res_d = '0;
    case (op_d)
      OP_ADD:  res_d = bus.a + bus.b;
      OP_SUB:  res_d = bus.a - bus.b;
      OP_AND:  res_d = bus.a & bus.b;
      OP_OR:   res_d = bus.a | bus.b;
      OP_XOR:  res_d = bus.a ^ bus.b;
      OP_SLL:  res_d = bus.a << shamt;
      OP_SRL:  res_d = bus.a >> shamt;
      OP_SRA:  res_d = $unsigned($signed(bus.a) >>> shamt);
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: res_d = '0;
    endcase
  end

  // Control FSM, multiplier iteration and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      op_q        <= 4'b0000;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // A drain clears valid unless a load below sets it again on the same edge.
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && op_d == OP_MUL) begin
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL;
          end else if (accept) begin
            result_q    <= res_d;
            zero_q      <= (res_d == '0);
            op_q        <= op_d;
            illegal_q   <= (op_d == OP_ILL);
            out_valid_q <= 1'b1;
          end
        end
        MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SW'(WIDTH-1)) state_q <= DONE;
        end
        DONE: begin
          if (out_free) begin
            result_q    <= acc_q;
            zero_q      <= (acc_q == '0);
            op_q        <= OP_MUL;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed bench for alu_ctrl_exec (WIDTH=64, MUL_EN=1).
module tb_alu_ctrl_exec;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_exec_if #(.WIDTH(64)) bus();
  alu_ctrl_exec #(.WIDTH(64), .MUL_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] op, input logic [3:0] f, input logic m,
                      input logic [63:0] av, input logic [63:0] bv);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = f;
    bus.mext     = m;
    bus.a        = av;
    bus.b        = bv;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] res, input logic [3:0] op,
                         input logic z, input logic ill);
    chk({tag, ".valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, ".result"}, bus.result, res);
    chk({tag, ".op"}, {60'd0, bus.operation}, {60'd0, op});
    chk({tag, ".zero"}, {63'd0, bus.zero}, {63'd0, z});
    chk({tag, ".illegal"}, {63'd0, bus.illegal}, {63'd0, ill});
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_op = 2'b00; bus.funct = 4'h0; bus.mext = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst.result", bus.result, 64'd0);
    chk("rst.zero", {63'd0, bus.zero}, 64'd1);
    chk("rst.op", {60'd0, bus.operation}, 64'd0);
    chk("rst.illegal", {63'd0, bus.illegal}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle.in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Single-cycle ops
    send(2'b10, 4'b0000, 1'b0, 64'd5, 64'd7);
    chk_out("add", 64'd12, 4'b0010, 1'b0, 1'b0);
    send(2'b01, 4'b0000, 1'b0, 64'd9, 64'd9);
    chk_out("branch_sub", 64'd0, 4'b0110, 1'b1, 1'b0);
    send(2'b10, 4'b1101, 1'b0, 64'h8000_0000_0000_0000, 64'd4);
    chk_out("sra", 64'hF800_0000_0000_0000, 4'b0111, 1'b0, 1'b0);
    send(2'b10, 4'b0010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk_out("slt", 64'd1, 4'b1000, 1'b0, 1'b0);
    send(2'b10, 4'b0111, 1'b0, 64'hF0, 64'h3C);
    chk_out("and", 64'h30, 4'b0000, 1'b0, 1'b0);
    send(2'b10, 4'b0110, 1'b0, 64'hF0, 64'h0F);
    chk_out("or", 64'hFF, 4'b0001, 1'b0, 1'b0);
    send(2'b10, 4'b0100, 1'b0, 64'hFF, 64'h0F);
    chk_out("xor", 64'hF0, 4'b0011, 1'b0, 1'b0);
    send(2'b10, 4'b0001, 1'b0, 64'd1, 64'h43);   // only b[5:0]=3 counts
    chk_out("sll", 64'd8, 4'b0100, 1'b0, 1'b0);
    send(2'b10, 4'b0101, 1'b0, 64'h8000_0000_0000_0000, 64'd63);
    chk_out("srl", 64'd1, 4'b0101, 1'b0, 1'b0);
    send(2'b10, 4'b1000, 1'b0, 64'd3, 64'd5);
    chk_out("sub_wrap", 64'hFFFF_FFFF_FFFF_FFFE, 4'b0110, 1'b0, 1'b0);
    send(2'b00, 4'b1111, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk_out("ldst_add_wrap", 64'd0, 4'b0010, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain.valid", {63'd0, bus.out_valid}, 64'd0);

    // MUL: in_ready low for WIDTH+1 cycles, result after that
    send(2'b10, 4'b0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    n = 0;
    for (int i = 0; i < 200 && !bus.out_valid; i++) begin
      if (!bus.in_ready) n++;
      @(negedge clk);
    end
    chk("mul.busy_cycles", 64'(n), 64'd65);
    chk_out("mul", 64'hFFFF_FFFF_FFFF_FFFD, 4'b1010, 1'b0, 1'b0);
    chk("mul.in_ready_after", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);

    // Backpressure: held result stays put, no accepts
    bus.out_ready = 1'b0;
    send(2'b10, 4'b0000, 1'b0, 64'd1, 64'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp.result", bus.result, 64'd3);
      chk("bp.in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp.valid", {63'd0, bus.out_valid}, 64'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(2'b10, 4'b0000, 1'b0, 64'd10, 64'd20);
    chk_out("b2b0", 64'd30, 4'b0010, 1'b0, 1'b0);
    send(2'b10, 4'b0100, 1'b0, 64'd100, 64'd1);
    chk_out("b2b1", 64'd101, 4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.drain", {63'd0, bus.out_valid}, 64'd0);

    // Illegal encodings
    send(2'b11, 4'b0000, 1'b0, 64'd5, 64'd5);
    chk_out("ill_aluop", 64'd0, 4'b1111, 1'b1, 1'b1);
    send(2'b10, 4'b0001, 1'b1, 64'd5, 64'd5);
    chk_out("ill_mext", 64'd0, 4'b1111, 1'b1, 1'b1);
    send(2'b10, 4'b0011, 1'b0, 64'd5, 64'd5);
    chk_out("ill_funct", 64'd0, 4'b1111, 1'b1, 1'b1);
    send(2'b00, 4'b0000, 1'b0, 64'd5, 64'd5);
    chk_out("legal_again", 64'd10, 4'b0010, 1'b0, 1'b0);

    // Reset mid-MUL: immediate return, nothing emitted later
    send(2'b10, 4'b0000, 1'b1, 64'd3, 64'd3);
    repeat (10) @(negedge clk);
    chk("mid.in_ready", {63'd0, bus.in_ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk("midrst.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst.result", bus.result, 64'd0);
    chk("midrst.zero", {63'd0, bus.zero}, 64'd1);
    chk("midrst.op", {60'd0, bus.operation}, 64'd0);
    chk("midrst.in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("midrst.no_stale", 64'(n), 64'd0);
    chk("midrst.idle", {63'd0, bus.in_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
